// File: rtl/hack_alu_pkg.sv
// Shared definitions for the extended Hack ALU and the shift-and-add multiply sequencer.
package hack_alu_pkg;

   localparam int ALU_INSTR_W = 9;

   localparam logic [ALU_INSTR_W-1:0] ALU_INSTR_ADD   = 9'b11_0_000010;
   localparam logic [ALU_INSTR_W-1:0] ALU_INSTR_SHL_X = 9'b01_0_110000;
   localparam logic [ALU_INSTR_W-1:0] ALU_INSTR_SHR_Y = 9'b01_0_000000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADD  = 3'd1,
      ST_SHL  = 3'd2,
      ST_SHR  = 3'd3,
      ST_DONE = 3'd4
   } mul_state_t;

endpackage

// File: rtl/hack_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the shared Hack ALU, one instruction per cycle.
// Optional macro HACK_MUL_EARLY_EXIT_EN: finish as soon as the shifted multiplier reaches zero.
module hack_mul_sequencer
   import hack_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       product,
   output logic [WIDTH-1:0]       alu_x,
   output logic [WIDTH-1:0]       alu_y,
   output logic [ALU_INSTR_W-1:0] alu_instruction,
   input  logic [WIDTH-1:0]       alu_out,
   input  logic                   alu_zr
);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mult_q, mult_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             early_exit;

`ifdef HACK_MUL_EARLY_EXIT_EN
   assign early_exit = alu_zr;
`else
   assign early_exit = alu_zr & 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mult_d    = mult_q;
      count_d   = count_q;
      product_d = product_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mcand_d = a;
                  mult_d  = b;
                  acc_d   = '0;
                  count_d = '0;
                  state_d = b[0] ? ST_ADD : ST_SHL;
               end
            end
            ST_ADD: begin
               acc_d   = alu_out;
               state_d = ST_SHL;
            end
            ST_SHL: begin
               mcand_d = alu_out;
               state_d = ST_SHR;
            end
            ST_SHR: begin
               mult_d  = alu_out;
               count_d = count_q + 1'b1;
               // acc is final here: the SHR step never touches it
               if (count_q == CNT_W'(WIDTH - 1) || early_exit) begin
                  state_d   = ST_DONE;
                  product_d = acc_q;
               end else begin
                  state_d = alu_out[0] ? ST_ADD : ST_SHL;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d == ST_ADD) || (state_d == ST_SHL) || (state_d == ST_SHR);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mult_q    <= '0;
         count_q   <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mult_q    <= mult_d;
         count_q   <= count_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // ALU drive depends only on registered state, never on start/a/b
   always_comb begin
      alu_x           = '0;
      alu_y           = '0;
      alu_instruction = ALU_INSTR_ADD;
      case (state_q)
         ST_ADD: begin
            alu_x           = acc_q;
            alu_y           = mcand_q;
            alu_instruction = ALU_INSTR_ADD;
         end
         ST_SHL: begin
            alu_x           = mcand_q;
            alu_instruction = ALU_INSTR_SHL_X;
         end
         ST_SHR: begin
            alu_y           = mult_q;
            alu_instruction = ALU_INSTR_SHR_Y;
         end
         default: begin
            alu_x           = '0;
            alu_y           = '0;
            alu_instruction = ALU_INSTR_ADD;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_hack_mul_sequencer.sv
// Self-checking bench for hack_mul_sequencer with a behavioural extended Hack ALU alongside.
module tb_hack_mul_sequencer;
   import hack_alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy, done;
   logic [15:0] product, alu_x, alu_y, alu_out;
   logic [8:0]  alu_instruction;
   logic        alu_zr;

   int n_cmp = 0;
   int n_mis = 0;
   int illegal_cnt = 0;

   always #5 clk = ~clk;

   hack_mul_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .a(a), .b(b),
      .busy(busy), .done(done), .product(product),
      .alu_x(alu_x), .alu_y(alu_y), .alu_instruction(alu_instruction),
      .alu_out(alu_out), .alu_zr(alu_zr)
   );

   // Extended Hack ALU: mode 11 = classic zx/nx/zy/ny/f/no, mode 01 = shift x left or y right
   logic [15:0] x1, y1, o1;
   always_comb begin
      x1 = alu_instruction[5] ? 16'h0 : alu_x;
      if (alu_instruction[4]) x1 = ~x1;
      y1 = alu_instruction[3] ? 16'h0 : alu_y;
      if (alu_instruction[2]) y1 = ~y1;
      o1 = alu_instruction[1] ? (x1 + y1) : (x1 & y1);
      alu_out = '0;
      case (alu_instruction[8:7])
         2'b11:   alu_out = alu_instruction[0] ? ~o1 : o1;
         2'b01:   alu_out = (alu_instruction[5:4] == 2'b11) ? (alu_x << 1)
                                                             : 16'($signed(alu_y) >>> 1);
         default: alu_out = '0;
      endcase
      alu_zr = (alu_out == 16'h0);
   end

   always @(negedge clk) if (!reset && !alu_instruction[7]) illegal_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_cycles(input logic [15:0] bv);
      int iters = 16;
`ifdef HACK_MUL_EARLY_EXIT_EN
      if (!bv[15]) begin
         iters = 1;
         for (int i = 0; i < 16; i++) if (bv[i]) iters = i + 1;
      end
`endif
      return 2 * iters + $countones(bv);
   endfunction

   task automatic launch(input logic [15:0] ta, input logic [15:0] tb_v);
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic got);
      cyc = 0; got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin got = 1'b1; break; end
         if (busy) cyc++;
         @(negedge clk);
      end
   endtask

   task automatic do_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb_v);
      int cyc; logic got; logic [15:0] ep;
      ep = ta * tb_v;
      launch(ta, tb_v);
      wait_done(cyc, got);
      chk({tag, "_done"}, 32'(got), 32'd1);
      chk({tag, "_prod"}, 32'(product), 32'(ep));
      chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cycles(tb_v)));
   endtask

   initial begin
      int cyc; logic got; logic saw; logic [15:0] ra, rb, prev;
      logic [15:0] ab_b;

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_prod", 32'(product), 32'd0);
      chk("rst_instr", 32'(alu_instruction), 32'(ALU_INSTR_ADD));
      chk("rst_xy", {alu_x, alu_y}, 32'd0);
      reset = 1'b0;

      do_mul("m3x5", 16'd3, 16'd5);
      do_mul("mneg7x6", 16'hFFF9, 16'd6);
      do_mul("wrap", 16'h0100, 16'h0100);
      do_mul("m3x1", 16'd3, 16'd1);
      do_mul("b2b_b0", 16'h1234, 16'd0);

      // start held through DONE must not be taken until IDLE
      launch(16'd5, 16'd7);
      wait_done(cyc, got);
      a = 16'd9; b = 16'd11; start = 1'b1;
      @(negedge clk);
      chk("start_in_done_busy", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("start_after_done_busy", 32'(busy), 32'd1);
      wait_done(cyc, got);
      chk("start_after_done_prod", 32'(product), 32'd99);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         do_mul("rand", ra, rb);
         @(negedge clk);
         chk("rand_pulse", {15'd0, done, 15'd0, busy}, 32'd0);
      end

      // new start while busy is dropped
      launch(16'd2, 16'd3);
      repeat (4) @(negedge clk);
      a = 16'd9; b = 16'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, got);
      chk("midstart_prod", 32'(product), 32'd6);
      chk("midstart_cyc", 32'(cyc + 5), 32'(exp_cycles(16'd3)));

      do_mul("pre_abort", 16'd123, 16'd45);
      prev = product;
`ifdef HACK_MUL_EARLY_EXIT_EN
      ab_b = 16'h8003;
`else
      ab_b = 16'd3;
`endif
      launch(16'd2, ab_b);
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_idle", {15'd0, busy, 15'd0, done}, 32'd0);
      saw = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done || busy) saw = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(saw), 32'd0);
      chk("abort_prod_kept", 32'(product), 32'(prev));

      a = 16'd7; b = 16'd7; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_start_prod", 32'(product), 32'(prev));

      launch(16'd2, 16'd3);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async_rst_ctl", {15'd0, busy, 15'd0, done}, 32'd0);
      chk("async_rst_prod", 32'(product), 32'd0);
      chk("async_rst_xy", {alu_x, alu_y}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      do_mul("post_rst", 16'hFFFF, 16'hFFFF);

      chk("no_illegal_instr", 32'(illegal_cnt), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
